// File: rtl/avalon_timer_pkg.sv
// Shared constants for the parametrised Avalon-MM interval timer: register map,
// control/status bit positions and the counter-width legality rule.
package avalon_timer_pkg;

  localparam int BUS_W     = 16;
  localparam int ADDR_W    = 4;
  localparam int MAX_WORDS = 4;

  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD0 = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD1 = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD2 = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD3 = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_SNAP0   = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_SNAP1   = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_SNAP2   = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_SNAP3   = 4'd9;

  localparam int STATUS_TO_BIT  = 0;
  localparam int STATUS_RUN_BIT = 1;
  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  localparam int COUNTER_W_MIN = 16;
  localparam int COUNTER_W_MAX = 64;

  function automatic bit counter_w_legal(input int w);
    return (w % BUS_W == 0) && (w >= COUNTER_W_MIN) && (w <= COUNTER_W_MAX);
  endfunction

  // Selects one 16-bit bus word out of a zero-extended 64-bit register image.
  function automatic logic [BUS_W-1:0] word_of(input logic [63:0] v, input logic [1:0] idx);
    return v[16*idx +: 16];
  endfunction

endpackage

// File: rtl/avalon_param_interval_timer_if.sv
// Avalon-MM slave bus of the interval timer plus its level interrupt.
interface avalon_param_interval_timer_if;
  import avalon_timer_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;
  logic              irq;

  modport slave  (input  address, chipselect, write_n, writedata, output readdata, irq);
  modport master (output address, chipselect, write_n, writedata, input  readdata, irq);
endinterface

// File: rtl/timer_down_counter.sv
// Down counter with zero detect and reload; owns the RUN flag and reports a
// one-cycle timeout whenever a running count at zero reloads.
module timer_down_counter #(
  parameter int          COUNTER_W    = 32,
  parameter logic [63:0] RESET_PERIOD = 64'h7A11F,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COUNTER_W-1:0] period,
  input  logic                 cont,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 reload_req,
  output logic [COUNTER_W-1:0] count,
  output logic                 run,
  output logic                 timeout
);

  logic [COUNTER_W-1:0] count_d, count_q;
  logic                 run_d, run_q;
  logic                 reload_d, reload_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    count_d  = count_q;
    run_d    = run_q;
    reload_d = reload_req;
    timeout  = 1'b0;

    if (reload_q) begin
      count_d = period;
    end else if (run_q) begin
      if (count_q == '0) begin
        count_d = period;
        timeout = 1'b1;
        if (!cont) run_d = 1'b0;
      end else begin
        count_d = count_q - COUNTER_W'(1);
      end
    end

    // Register writes override the counter's own RUN update; STOP beats START.
    if (start)      run_d = 1'b1;
    if (stop)       run_d = 1'b0;
    if (reload_req) run_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      count_q  <= RESET_PERIOD[COUNTER_W-1:0];
      run_q    <= AUTO_START;
      reload_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      run_q    <= run_d;
      reload_q <= reload_d;
    end
  end

  assign count = count_q;
  assign run   = run_q;

endmodule

// File: rtl/avalon_param_interval_timer.sv
// Avalon-MM interval timer top: register file, registered read mux, irq.
// Optional counter snapshot at addr 6..9 is built when TIMER_SNAPSHOT_EN is defined.
module avalon_param_interval_timer
  import avalon_timer_pkg::*;
#(
  parameter int          COUNTER_W    = 32,
  parameter logic [63:0] RESET_PERIOD = 64'h7A11F,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  avalon_param_interval_timer_if.slave  bus
);

  localparam int N_WORDS = COUNTER_W / BUS_W;

  if (!counter_w_legal(COUNTER_W)) begin : g_bad_counter_w
    $error("COUNTER_W must be a multiple of 16 within 16..64");
  end

  logic                 wr;
  logic [COUNTER_W-1:0] period_d, period_q;
  logic [63:0]          period_ext, period_rd, snap_rd;
  logic                 to_d, to_q;
  logic                 ito_d, ito_q;
  logic                 cont_d, cont_q;
  logic [BUS_W-1:0]     readdata_d, readdata_q;
  logic                 start, stop, reload_req;
  logic [COUNTER_W-1:0] count;
  logic                 run, timeout;

  assign wr = bus.chipselect & ~bus.write_n;

  // Period words beyond COUNTER_W fall off the truncation and raise no reload.
  always_comb begin
    period_ext = 64'(period_q);
    reload_req = 1'b0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (wr && (bus.address == ADDR_PERIOD0 + 4'(i)) && (i < N_WORDS)) begin
        period_ext[16*i +: 16] = bus.writedata;
        reload_req             = 1'b1;
      end
    end
    period_d = period_ext[COUNTER_W-1:0];
  end

  always_comb begin
    to_d   = to_q;
    ito_d  = ito_q;
    cont_d = cont_q;
    start  = 1'b0;
    stop   = 1'b0;
    if (wr && bus.address == ADDR_STATUS) to_d = 1'b0;
    if (timeout)                          to_d = 1'b1;
    if (wr && bus.address == ADDR_CONTROL) begin
      ito_d  = bus.writedata[CTRL_ITO_BIT];
      cont_d = bus.writedata[CTRL_CONT_BIT];
      start  = bus.writedata[CTRL_START_BIT];
      stop   = bus.writedata[CTRL_STOP_BIT];
    end
  end

  timer_down_counter #(
    .COUNTER_W    (COUNTER_W),
    .RESET_PERIOD (RESET_PERIOD),
    .AUTO_START   (AUTO_START)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .period     (period_q),
    .cont       (cont_q),
    .start      (start),
    .stop       (stop),
    .reload_req (reload_req),
    .count      (count),
    .run        (run),
    .timeout    (timeout)
  );

`ifdef TIMER_SNAPSHOT_EN
  logic [COUNTER_W-1:0] snap_d, snap_q;

  assign snap_d  = (wr && bus.address == ADDR_SNAP0) ? count : snap_q;
  assign snap_rd = 64'(snap_q);

  always_ff @(posedge clk) begin
    if (reset) snap_q <= '0;
    else       snap_q <= snap_d;
  end
`else
  logic unused_count;

  assign unused_count = ^count;
  assign snap_rd      = '0;
`endif

  assign period_rd = 64'(period_q);

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_STATUS: begin
        readdata_d[STATUS_TO_BIT]  = to_q;
        readdata_d[STATUS_RUN_BIT] = run;
      end
      ADDR_CONTROL: begin
        readdata_d[CTRL_ITO_BIT]  = ito_q;
        readdata_d[CTRL_CONT_BIT] = cont_q;
      end
      ADDR_PERIOD0: readdata_d = word_of(period_rd, 2'd0);
      ADDR_PERIOD1: readdata_d = word_of(period_rd, 2'd1);
      ADDR_PERIOD2: readdata_d = word_of(period_rd, 2'd2);
      ADDR_PERIOD3: readdata_d = word_of(period_rd, 2'd3);
      ADDR_SNAP0:   readdata_d = word_of(snap_rd, 2'd0);
      ADDR_SNAP1:   readdata_d = word_of(snap_rd, 2'd1);
      ADDR_SNAP2:   readdata_d = word_of(snap_rd, 2'd2);
      ADDR_SNAP3:   readdata_d = word_of(snap_rd, 2'd3);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q   <= RESET_PERIOD[COUNTER_W-1:0];
      to_q       <= 1'b0;
      ito_q      <= 1'b0;
      cont_q     <= AUTO_START;
      readdata_q <= '0;
    end else begin
      period_q   <= period_d;
      to_q       <= to_d;
      ito_q      <= ito_d;
      cont_q     <= cont_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = to_q & ito_q;

endmodule

// File: tb/tb_avalon_param_interval_timer.sv
// Self-checking bench for avalon_param_interval_timer: directed test-plan steps
// followed by random bus traffic, all checked against a behavioural model.
module tb_avalon_param_interval_timer;

`ifdef TIMER_SNAPSHOT_EN
  localparam int CW   = 64;
  localparam bit SNAP = 1'b1;
`else
  localparam int CW   = 32;
  localparam bit SNAP = 1'b0;
`endif
  localparam int          NW    = CW / 16;
  localparam logic [63:0] RST_P = 64'd4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  avalon_param_interval_timer_if bus_if ();

  avalon_param_interval_timer #(
    .COUNTER_W    (CW),
    .RESET_PERIOD (RST_P),
    .AUTO_START   (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [63:0] m_count, m_period, m_snap;
  bit          m_run, m_cont, m_ito, m_to, m_pend;
  logic [15:0] m_rd;

  function automatic logic [63:0] mask_w(input logic [63:0] v);
    return v & ((64'd1 << CW) - 64'd1);
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] a);
    logic [63:0] v;
    int          idx;
    if (a == 4'd0) return {14'd0, m_run, m_to};
    if (a == 4'd1) return {14'd0, m_cont, m_ito};
    if (a >= 4'd2 && a <= 4'd5) begin
      idx = int'(a) - 2;
      v   = m_period;
    end else if (a >= 4'd6 && a <= 4'd9) begin
      idx = int'(a) - 6;
      v   = SNAP ? m_snap : 64'd0;
    end else begin
      return 16'd0;
    end
    return (idx < NW) ? v[idx*16 +: 16] : 16'd0;
  endfunction

  task automatic model_reset();
    m_count  = RST_P;
    m_period = RST_P;
    m_run    = 1'b1;
    m_cont   = 1'b1;
    m_ito    = 1'b0;
    m_to     = 1'b0;
    m_pend   = 1'b0;
    m_snap   = 64'd0;
    m_rd     = 16'd0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, advance the model by one clock, sample #1 after the edge.
  task automatic step(input logic [3:0] a, input bit cs, input bit wn,
                      input logic [15:0] wd, input bit rst, input string tag);
    bit          wr, tick, n_run, n_to, n_pend, n_ito, n_cont;
    logic [63:0] n_count, n_period, n_snap;
    logic [15:0] n_rd;
    int          idx;
    bus_if.address    = a;
    bus_if.chipselect = cs;
    bus_if.write_n    = wn;
    bus_if.writedata  = wd;
    reset             = rst;

    wr       = cs && !wn;
    n_rd     = m_read(a);
    tick     = !m_pend && m_run && (m_count == 64'd0);
    n_count  = m_pend ? m_period : (m_run ? (m_count == 64'd0 ? m_period : m_count - 64'd1) : m_count);
    n_to     = (m_to && !(wr && a == 4'd0)) || tick;
    n_run    = m_run && !(tick && !m_cont);
    n_ito    = m_ito;
    n_cont   = m_cont;
    n_period = m_period;
    n_pend   = 1'b0;
    n_snap   = m_snap;
    if (wr && a >= 4'd2 && a <= 4'd5 && (int'(a) - 2) < NW) begin
      idx = int'(a) - 2;
      n_period[idx*16 +: 16] = wd;
      n_period = mask_w(n_period);
      n_pend   = 1'b1;
      n_run    = 1'b0;
    end
    if (wr && a == 4'd1) begin
      n_ito  = wd[0];
      n_cont = wd[1];
      if (wd[2]) n_run = 1'b1;
      if (wd[3]) n_run = 1'b0;
    end
    if (SNAP && wr && a == 4'd6) n_snap = m_count;

    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_count  = n_count;
      m_period = n_period;
      m_run    = n_run;
      m_cont   = n_cont;
      m_ito    = n_ito;
      m_to     = n_to;
      m_pend   = n_pend;
      m_snap   = n_snap;
      m_rd     = n_rd;
    end
    check({tag, ".rd"}, bus_if.readdata, m_rd);
    check({tag, ".irq"}, bus_if.irq, m_to & m_ito);
  endtask

  task automatic idle(input logic [3:0] a, input string tag);
    step(a, 1'b0, 1'b1, 16'h0, 1'b0, tag);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] wd, input string tag);
    step(a, 1'b1, 1'b0, wd, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    bus_if.address    = 4'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 16'h0;
    reset             = 1'b1;

    // Reset state
    step(4'd0, 1'b0, 1'b1, 16'h0, 1'b1, "reset0");
    step(4'd0, 1'b0, 1'b1, 16'h0, 1'b1, "reset1");
    check("reset_readdata", bus_if.readdata, 16'h0);
    check("reset_irq", bus_if.irq, 1'b0);

    // Auto-start, period 4: first timeout on the 5th edge, then every 5
    for (int i = 0; i < 5; i++) idle(4'd0, "auto");
    check("to_not_yet", bus_if.readdata, 16'h2);
    idle(4'd0, "auto");
    check("to_after_5", bus_if.readdata, 16'h3);
    wr_reg(4'd0, 16'h0, "clr_to");
    for (int i = 0; i < 3; i++) idle(4'd0, "period5");
    check("period5_pre", bus_if.readdata, 16'h2);
    idle(4'd0, "period5");
    check("period5_hit", bus_if.readdata, 16'h3);
    check("irq_masked", bus_if.irq, 1'b0);

    // Interrupt enable and clearing
    wr_reg(4'd1, 16'h3, "ctrl_ito_cont");
    wr_reg(4'd0, 16'h0, "clr_to2");
    check("irq_cleared", bus_if.irq, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (bus_if.irq) break;
      idle(4'd0, "wait_irq");
    end
    check("irq_on_timeout", bus_if.irq, 1'b1);
    wr_reg(4'd0, 16'h0, "clr_to3");
    check("irq_clear_next", bus_if.irq, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (m_run && !m_pend && m_count == 64'd0) break;
      idle(4'd0, "wait_zero");
    end
    wr_reg(4'd0, 16'h0, "clr_vs_to");
    check("clear_vs_timeout_irq", bus_if.irq, 1'b1);
    idle(4'd0, "clr_vs_to_rd");
    check("clear_vs_timeout_status", bus_if.readdata, 16'h3);

    // New period 2, one-shot
    wr_reg(4'd0, 16'h0, "clr_to4");
    wr_reg(4'd2, 16'h0002, "p0");
    wr_reg(4'd3, 16'h0000, "p1");
    idle(4'd2, "rb_p0");
    check("period0_rb", bus_if.readdata, 16'h2);
    idle(4'd0, "rb_status");
    check("oneshot_stopped", bus_if.readdata, 16'h0);
    wr_reg(4'd1, 16'h4, "oneshot_start");
    for (int i = 0; i < 3; i++) idle(4'd0, "oneshot");
    check("oneshot_running", bus_if.readdata, 16'h2);
    idle(4'd0, "oneshot");
    check("oneshot_done", bus_if.readdata, 16'h1);
    for (int i = 0; i < 4; i++) idle(4'd0, "oneshot_idle");
    check("oneshot_single", bus_if.readdata, 16'h1);

    // Stop freezes the counter, start resumes from the frozen value
    wr_reg(4'd0, 16'h0, "clr_to5");
    wr_reg(4'd1, 16'h6, "run_cont");
    wr_reg(4'd1, 16'hC, "start_stop");
    idle(4'd0, "stopped");
    check("stopped_status", bus_if.readdata, 16'h0);
    for (int i = 0; i < 3; i++) idle(4'd0, "frozen");
    wr_reg(4'd1, 16'h6, "resume");
    idle(4'd0, "resume");
    idle(4'd0, "resume");
    check("resume_pre", bus_if.readdata, 16'h2);
    idle(4'd0, "resume");
    check("resume_hit", bus_if.readdata, 16'h3);

    // Upper period words and unmapped addresses
    wr_reg(4'd4, 16'hABCD, "p2");
    idle(4'd4, "rb_p2");
    check("period2_rb", bus_if.readdata, (NW > 2) ? 64'hABCD : 64'h0);
    wr_reg(4'd4, 16'h0, "p2_clr");
    idle(4'd10, "rd10");
    check("unmapped_10", bus_if.readdata, 16'h0);
    idle(4'd15, "rd15");
    check("unmapped_15", bus_if.readdata, 16'h0);

    // Snapshot of counter at the write edge (period 0x1_0000_0005 when 64-bit)
    wr_reg(4'd2, 16'h0005, "sp0");
    wr_reg(4'd3, 16'h0000, "sp1");
    wr_reg(4'd4, 16'h0001, "sp2");
    wr_reg(4'd5, 16'h0000, "sp3");
    wr_reg(4'd1, 16'h6, "snap_run");
    for (int i = 0; i < 3; i++) idle(4'd0, "snap_cnt");
    wr_reg(4'd6, 16'h0, "snap_take");
    idle(4'd6, "snap_w0");
    check("snap_word0", bus_if.readdata, SNAP ? 64'h2 : 64'h0);
    idle(4'd7, "snap_w1");
    check("snap_word1", bus_if.readdata, 16'h0);
    idle(4'd8, "snap_w2");
    check("snap_word2", bus_if.readdata, SNAP ? 64'h1 : 64'h0);
    idle(4'd9, "snap_w3");
    check("snap_word3", bus_if.readdata, 16'h0);
    idle(4'd10, "snap_rd10");
    check("snap_unmapped_10", bus_if.readdata, 16'h0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [3:0]  a;
      logic [15:0] wd;
      bit          cs, wn, rst;
      a   = 4'($urandom_range(0, 11));
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) begin
        cs = 1'b1;
        wn = 1'b0;
      end else begin
        cs = 1'($urandom_range(0, 1));
        wn = (cs == 1'b1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (a == 4'd2)                     wd = 16'($urandom_range(0, 9));
      else if (a >= 4'd3 && a <= 4'd5)   wd = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
      else if (a == 4'd1)                wd = 16'($urandom_range(0, 15));
      else                               wd = 16'($urandom);
      step(a, cs, wn, wd, rst, "rand");
    end

    // Reset in the middle of counting
    wr_reg(4'd1, 16'h7, "pre_reset_run");
    step(4'd0, 1'b1, 1'b0, 16'h0, 1'b1, "midreset");
    check("midreset_readdata", bus_if.readdata, 16'h0);
    check("midreset_irq", bus_if.irq, 1'b0);
    for (int i = 0; i < 5; i++) idle(4'd0, "post_reset");
    check("midreset_to_not_yet", bus_if.readdata, 16'h2);
    idle(4'd0, "post_reset");
    check("midreset_to_after_5", bus_if.readdata, 16'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
